int_ctrl: RTL and testbench
===========================

# int_ctrl

Programmable interrupt controller between the external device interrupt lines and the CP0 `HWInt[5:0]` input. It synchronizes up to six raw sources and latches each as level- or rising-edge-triggered. It masks the latched bits and drives a registered `hwint` vector into CP0. Software configures and services it through a small memory-mapped register window on the system bridge; a claim read returns and retires the highest-priority source.

## Interface
Parameters:
- `NSRC`, default 6: number of sources, legal range 1..6; unused `hwint` bits tie to 0.

Ports (reset is synchronous and active-high; clock is `clk`):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `src`  in  NSRC  raw asynchronous device interrupt lines
- `addr`  in  2  word select (bridge address bits [3:2])
- `we`  in  1  register write strobe, one cycle
- `re`  in  1  register read strobe, one cycle; only needed for the claim side effect
- `wdata`  in  32  write data
- `rdata`  out  32  read data, combinational from `addr`
- `hwint`  out  6  registered interrupt vector to CP0 `HWInt`

## Operation
Register map (word offsets):
- 0x0 MODE (RW): bit i = 1 means rising-edge mode; bit i = 0 means level mode.
- 0x4 ENABLE (RW): per-source mask.
- 0x8 PENDING:
  - Read returns the latched pending bits.
  - Write 1 clears edge-mode bits; level-mode bits ignore writes.
- 0xC CLAIM (RO):
  - `{valid, 28'b0, idx[2:0]}`. `valid` = |(PENDING & ENABLE); `idx` = lowest-numbered enabled pending source, 0 when not valid.
  - A read with `re`=1 and `valid`=1 clears pending[idx] if that source is in edge mode. Writes are ignored.

Register widths and read-back:
- Bits above NSRC-1 in every register read 0, and writes to them are discarded.

Source path, per source i:
- Three-flop chain `s1 <= src`, `s2 <= s1`, `s3 <= s2`.
- Level mode: `pending[i] <= s2[i]` every cycle.
- Edge mode: `pending[i]` sets when `s2 & ~s3`, and holds until cleared by a PENDING write-1 or a claim.
- `hwint[i] <= pending[i] & enable[i]` every cycle.

Priority and simultaneous events:
- Edge set in the same cycle as a W1C or claim clear: the set wins and the bit stays 1.
- A W1C and a claim in the same cycle on different bits: both apply.
- MODE write: `pending` clears for every bit whose mode changes. It re-evaluates under the new mode from the next cycle.
- ENABLE write: affects `hwint` and CLAIM only; `pending` is unchanged.

Reset:
- Clears MODE, ENABLE, pending, s1/s2/s3 and `hwint` to 0.
- `rdata` reads 0 at every address.
- Reset asserted mid-operation discards any captured edges.

## Timing
Latency to `hwint`:
- `src` first sampled high at edge k: `pending` updates at edge k+2 and `hwint` at edge k+3. This holds for both modes.
- An edge pulse is captured only if `src` is held for at least one sampling edge.

Register writes (`we` at edge k):
- MODE, ENABLE and PENDING take their new value after edge k.
- `hwint` reflects the write after edge k+1.

Claim (`re` at edge k, offset 0xC):
- `rdata` shows pre-clear contents during that cycle.
- `pending` clears at edge k, and `hwint` falls at edge k+1.

Back-to-back operations:
- Accesses are permitted every cycle.
- A claim read in the cycle after a claim observes the updated state.

Other rules:
- Level source deasserted: `hwint` drops 3 cycles after the first low sample. W1C and claim have no effect on level sources.
- `hwint` is glitch-free and registered; CP0 samples it directly.

## Test plan
- **Reset and read-back:** assert reset with `src`=6'h3F → `hwint`=0 and all four addresses read 0. Release reset → level source 0 sets `hwint[0]`=1 exactly 3 cycles later only after ENABLE=1.
- **Level mode:** ENABLE=6'h3F, MODE=0, pulse `src[2]` high for 5 cycles → `hwint[2]` high for 5 cycles, delayed 3 cycles. W1C 0x8 = 4 while high → no change.
- **Edge mode:** MODE=6'h3F, ENABLE=6'h3F, 1-cycle pulse on `src[4]` → `hwint[4]` latches 1. Write 0x8 = 6'h10 → `hwint[4]`=0 one cycle later.
- **Claim:** pend edge sources 1 and 3 → CLAIM reads 0x80000001 and clears bit 1. Next claim reads 0x80000003. Next reads 0x00000000.
- **Collision:** new edge on `src[3]` reaches the `s2 & ~s3` condition in the same cycle as the W1C of bit 3 → pending[3] stays 1.
- **Masking and mode change:** pend edge source 5 with ENABLE[5]=0 → `hwint[5]`=0 and CLAIM valid=0. Set ENABLE[5] → `hwint[5]`=1 next cycle. Write MODE[5]=0 with `src[5]` low → pending[5] clears.

Source files
------------

// File: rtl/int_ctrl.sv
// Programmable interrupt controller feeding CP0 HWInt: synchronizes raw sources,
// latches them as level or rising-edge, masks them and exposes a claim register.
module int_ctrl #(
    parameter int unsigned NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic            re,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [5:0]      hwint
);

    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] mode, enable, pending;
    logic [NSRC-1:0] pending_next, visible, rise, clr, mode_chg;
    logic [5:0]      hwint_next;
    logic [2:0]      idx;
    logic            valid;
    logic            wr_mode, wr_en, wr_pend, claim;
    logic            unused_wdata;

    assign unused_wdata = ^wdata[31:NSRC];

    assign visible = pending & enable;
    assign rise    = s2 & ~s3;
    assign wr_mode = we & (addr == 2'd0);
    assign wr_en   = we & (addr == 2'd1);
    assign wr_pend = we & (addr == 2'd2);
    assign claim   = re & (addr == 2'd3) & valid & ~reset;

    // Lowest-numbered enabled pending source wins the claim.
    always_comb begin
        valid = |visible;
        idx   = '0;
        for (int unsigned i = NSRC; i > 0; i--) begin
            if (visible[i-1]) idx = 3'(i - 1);
        end
    end

    // A mode change clears the bit outright; edge sets beat any same-cycle clear.
    always_comb begin
        clr      = wr_pend ? wdata[NSRC-1:0] : '0;
        mode_chg = wr_mode ? (mode ^ wdata[NSRC-1:0]) : '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (claim && idx == 3'(i)) clr[i] = 1'b1;
        end
        pending_next = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (mode_chg[i])
                pending_next[i] = 1'b0;
            else if (mode[i])
                pending_next[i] = rise[i] | (pending[i] & ~clr[i]);
            else
                pending_next[i] = s2[i];
        end
    end

    always_comb begin
        hwint_next           = '0;
        hwint_next[NSRC-1:0] = visible;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            s3      <= '0;
            mode    <= '0;
            enable  <= '0;
            pending <= '0;
            hwint   <= '0;
        end else begin
            s1      <= src;
            s2      <= s1;
            s3      <= s2;
            pending <= pending_next;
            hwint   <= hwint_next;
            if (wr_mode) mode   <= wdata[NSRC-1:0];
            if (wr_en)   enable <= wdata[NSRC-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (!reset) begin
            case (addr)
                2'd0: rdata[NSRC-1:0] = mode;
                2'd1: rdata[NSRC-1:0] = enable;
                2'd2: rdata[NSRC-1:0] = pending;
                default: begin
                    rdata[31]  = valid;
                    rdata[2:0] = idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Randomized bench for int_ctrl, checked against a rule-level reference model.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src;
    logic [1:0]  addr;
    logic        we, re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [5:0]  hwint;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: registers plus a history of src samples, newest first.
    logic [5:0] m_mode = '0, m_en = '0, m_pend = '0, m_hw = '0;
    logic [5:0] hist[$];

    int_ctrl #(.NSRC(6)) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .addr  (addr),
        .we    (we),
        .re    (re),
        .wdata (wdata),
        .rdata (rdata),
        .hwint (hwint)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int lowest(input logic [5:0] v);
        for (int i = 0; i < 6; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        logic [5:0] vis;
        vis = m_pend & m_en;
        if (reset) return 32'h0;
        case (a)
            2'd0: return {26'h0, m_mode};
            2'd1: return {26'h0, m_en};
            2'd2: return {26'h0, m_pend};
            default: return (vis != 0) ? (32'h8000_0000 | lowest(vis)) : 32'h0;
        endcase
    endfunction

    // Applies the register rules for one clock edge using the inputs in force.
    task automatic model_edge();
        logic [5:0] old_s2, old_s3, vis, clr, nxt;
        int idx;
        if (reset) begin
            m_mode = '0; m_en = '0; m_pend = '0; m_hw = '0;
            hist = '{6'h0, 6'h0, 6'h0};
            return;
        end
        old_s2 = hist[1];
        old_s3 = hist[2];
        vis = m_pend & m_en;
        idx = lowest(vis);
        clr = (we && addr == 2'd2) ? wdata[5:0] : 6'h0;
        if (re && addr == 2'd3 && vis != 0) clr[idx] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (we && addr == 2'd0 && wdata[i] != m_mode[i])
                nxt[i] = 1'b0;
            else if (m_mode[i])
                nxt[i] = (old_s2[i] && !old_s3[i]) || (m_pend[i] && !clr[i]);
            else
                nxt[i] = old_s2[i];
        end
        m_hw   = vis;
        m_pend = nxt;
        if (we && addr == 2'd0) m_mode = wdata[5:0];
        if (we && addr == 2'd1) m_en   = wdata[5:0];
        hist.push_front(src);
        void'(hist.pop_back());
    endtask

    initial begin
        hist = '{6'h0, 6'h0, 6'h0};
        reset = 1'b1; src = 6'h3F; addr = '0; we = 0; re = 0; wdata = '0;
        @(posedge clk);
        model_edge();
        // Reset held with all sources high: everything reads 0.
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            addr = 2'(a);
            #1;
            check("reset_rdata", rdata, 32'h0);
            check("reset_hwint", {26'h0, hwint}, 32'h0);
            @(posedge clk);
            model_edge();
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < 6; b++)
                if ($urandom_range(0, 5) == 0) src[b] = ~src[b];
            addr  = 2'($urandom_range(0, 3));
            we    = ($urandom_range(0, 4) == 0);
            re    = ($urandom_range(0, 2) == 0);
            wdata = $urandom;
            // Keep mode writes rare so edge-mode pending bits get time to live.
            if (we && addr == 2'd0 && $urandom_range(0, 3) != 0) wdata[5:0] = m_mode;
            #1;
            check("rdata", rdata, model_rdata(addr));
            check("hwint", {26'h0, hwint}, {26'h0, m_hw});
            @(posedge clk);
            model_edge();
        end
        @(negedge clk);
        check("hwint_final", {26'h0, hwint}, {26'h0, m_hw});
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
